// File: rtl/rf_wgt_pp.sv
// Double-buffered (ping-pong) weight register file for one PE row.
// Weights stream serially into a shadow bank while the active bank feeds the MACs.
//
// Ports:
//   clk, rstn      - rising-edge clock, async active-low reset
//   wgt_in*        - serial weight word with valid/ready handshake
//   swap           - commit a full shadow bank to the active bank
//   rot            - rotate the active bank by one tap
//   clear          - flush the shadow bank (active bank untouched)
//   wgt_out        - active bank, tap i at [i*DW +: DW]
//   active_valid   - active bank holds committed weights
//   shadow_full    - shadow bank holds DEPTH words
//   load_cnt       - words currently in the shadow bank
//   swap_err       - one-cycle pulse after a swap request on a non-full shadow
module rf_wgt_pp #(
    parameter int DW    = 8,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [DW-1:0]       wgt_in,
    input  logic                wgt_in_valid,
    output logic                wgt_in_ready,
    input  logic                swap,
    input  logic                rot,
    input  logic                clear,
    output logic [DEPTH*DW-1:0] wgt_out,
    output logic                active_valid,
    output logic                shadow_full,
    output logic [CW-1:0]       load_cnt,
    output logic                swap_err
);

    typedef enum logic {
        S_LOAD,
        S_FULL
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] sh_q  [DEPTH];
    logic [DW-1:0] sh_d  [DEPTH];
    logic [DW-1:0] act_q [DEPTH];
    logic [DW-1:0] act_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          av_q, av_d;
    logic          err_q, err_d;
    logic          accept;
    logic          swap_take;

    // Clear has top priority on the shadow side and also suppresses the swap.
    assign accept    = wgt_in_valid && (state_q == S_LOAD);
    assign swap_take = swap && (state_q == S_FULL) && !clear;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        act_d   = act_q;
        av_d    = av_q;
        err_d   = 1'b0;

        if (clear) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            for (int i = 0; i < DEPTH; i++) begin
                sh_d[i] = '0;
            end
        end else if (swap_take) begin
            act_d   = sh_q;
            av_d    = 1'b1;
            cnt_d   = '0;
            state_d = S_LOAD;
        end else begin
            // A swap on the edge that loads the last word is still an error.
            err_d = swap;
            if (accept) begin
                sh_d[0] = wgt_in;
                for (int i = 1; i < DEPTH; i++) begin
                    sh_d[i] = sh_q[i-1];
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DEPTH - 1)) begin
                    state_d = S_FULL;
                end
            end
        end

        if (rot && av_q && !swap_take) begin
            act_d[0] = act_q[DEPTH-1];
            for (int i = 1; i < DEPTH; i++) begin
                act_d[i] = act_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            av_q    <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                sh_q[i]  <= '0;
                act_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            av_q    <= av_d;
            err_q   <= err_d;
            sh_q    <= sh_d;
            act_q   <= act_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_out
        assign wgt_out[g*DW +: DW] = act_q[g];
    end

    assign wgt_in_ready = (state_q == S_LOAD);
    assign shadow_full  = (state_q == S_FULL);
    assign load_cnt     = cnt_q;
    assign active_valid = av_q;
    assign swap_err     = err_q;

endmodule

// File: tb/tb_rf_wgt_pp.sv
// Self-checking bench for rf_wgt_pp.
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_rf_wgt_pp;

    localparam int DW    = 8;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [DW-1:0]       wgt_in = '0;
    logic                wgt_in_valid = 1'b0;
    logic                wgt_in_ready;
    logic                swap = 1'b0;
    logic                rot = 1'b0;
    logic                clear = 1'b0;
    logic [DEPTH*DW-1:0] wgt_out;
    logic                active_valid;
    logic                shadow_full;
    logic [CW-1:0]       load_cnt;
    logic                swap_err;

    int npass = 0;
    int ntot  = 0;

    rf_wgt_pp #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wgt_in       (wgt_in),
        .wgt_in_valid (wgt_in_valid),
        .wgt_in_ready (wgt_in_ready),
        .swap         (swap),
        .rot          (rot),
        .clear        (clear),
        .wgt_out      (wgt_out),
        .active_valid (active_valid),
        .shadow_full  (shadow_full),
        .load_cnt     (load_cnt),
        .swap_err     (swap_err)
    );

    always #5 clk = ~clk;

    // Model: shadow as a queue with newest word at index 0, active as a queue.
    logic [DW-1:0] m_sh[$];
    logic [DW-1:0] m_act[$];
    int            m_cnt;
    bit            m_av;
    bit            m_err;

    task automatic model_reset();
        m_sh.delete();
        m_act.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m_sh.push_back('0);
            m_act.push_back('0);
        end
        m_cnt = 0;
        m_av  = 0;
        m_err = 0;
    endtask

    task automatic model_step(input bit v, input logic [DW-1:0] w,
                              input bit s, input bit r, input bit c);
        bit full = (m_cnt == DEPTH);
        bit av0  = m_av;
        bit took = 0;
        logic [DW-1:0] t;
        m_err = 0;
        if (c) begin
            m_cnt = 0;
            foreach (m_sh[i]) m_sh[i] = '0;
        end else if (s && full) begin
            m_act = m_sh;
            m_av  = 1;
            m_cnt = 0;
            took  = 1;
        end else begin
            m_err = s;
            if (v && !full) begin
                m_sh.push_front(w);
                void'(m_sh.pop_back());
                m_cnt++;
            end
        end
        if (r && av0 && !took) begin
            t = m_act.pop_back();
            m_act.push_front(t);
        end
    endtask

    function automatic logic [DEPTH*DW-1:0] m_out();
        logic [DEPTH*DW-1:0] e;
        for (int i = 0; i < DEPTH; i++) e[i*DW +: DW] = m_act[i];
        return e;
    endfunction

    task automatic cycle(input bit v, input logic [DW-1:0] w,
                         input bit s, input bit r, input bit c);
        wgt_in_valid = v;
        wgt_in       = w;
        swap         = s;
        rot          = r;
        clear        = c;
        @(posedge clk);
        model_step(v, w, s, r, c);
        #1;
        wgt_in_valid = 0;
        swap         = 0;
        rot          = 0;
        clear        = 0;
    endtask

    task automatic test_reset();
        model_reset();
        rstn = 0;
        #23;
        rstn = 1;
        @(posedge clk);
        #1;
        ntot++;
        if (wgt_out !== '0) $display("FAIL reset_wgt_out got %h exp 0", wgt_out);
        else npass++;
        ntot++;
        if ({wgt_in_ready, shadow_full, active_valid, swap_err, load_cnt} !== {4'b1000, CW'(0)})
            $display("FAIL reset_flags got rdy=%b full=%b av=%b err=%b cnt=%0d exp 1 0 0 0 0",
                     wgt_in_ready, shadow_full, active_valid, swap_err, load_cnt);
        else npass++;
    endtask

    task automatic test_load();
        logic [DW-1:0] w[3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            cycle(1, w[i], 0, 0, 0);
            ntot++;
            if (load_cnt !== CW'(i + 1))
                $display("FAIL load_cnt%0d got %0d exp %0d", i, load_cnt, i + 1);
            else npass++;
        end
        ntot++;
        if ({shadow_full, wgt_in_ready, active_valid} !== 3'b100 || wgt_out !== '0)
            $display("FAIL load_full got full=%b rdy=%b av=%b out=%h exp 1 0 0 000000",
                     shadow_full, wgt_in_ready, active_valid, wgt_out);
        else npass++;
    endtask

    task automatic test_swap();
        cycle(0, 0, 1, 0, 0);
        ntot++;
        if (wgt_out !== 24'h112233)
            $display("FAIL swap_out got %h exp 112233", wgt_out);
        else npass++;
        ntot++;
        if ({active_valid, wgt_in_ready, shadow_full, load_cnt} !== {3'b110, CW'(0)})
            $display("FAIL swap_flags got av=%b rdy=%b full=%b cnt=%0d exp 1 1 0 0",
                     active_valid, wgt_in_ready, shadow_full, load_cnt);
        else npass++;
    endtask

    task automatic test_swap_err();
        cycle(1, 8'h44, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        ntot++;
        if (swap_err !== 1'b1 || wgt_out !== 24'h112233 || load_cnt !== CW'(1))
            $display("FAIL swap_err_pulse got err=%b out=%h cnt=%0d exp 1 112233 1",
                     swap_err, wgt_out, load_cnt);
        else npass++;
        cycle(0, 0, 0, 0, 0);
        ntot++;
        if (swap_err !== 1'b0)
            $display("FAIL swap_err_width got %b exp 0", swap_err);
        else npass++;
    endtask

    task automatic test_rot();
        cycle(0, 0, 0, 1, 0);
        ntot++;
        if (wgt_out !== 24'h223311)
            $display("FAIL rot_one got %h exp 223311", wgt_out);
        else npass++;
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        ntot++;
        if (wgt_out !== 24'h332211 && wgt_out !== 24'h112233)
            $display("FAIL rot_three got %h exp 112233", wgt_out);
        else if (wgt_out !== 24'h112233)
            $display("FAIL rot_three got %h exp 112233", wgt_out);
        else npass++;
    endtask

    task automatic test_swap_rot();
        cycle(0, 0, 0, 0, 1);
        cycle(1, 8'h80, 0, 0, 0);
        cycle(1, 8'h7F, 0, 0, 0);
        cycle(1, 8'h01, 0, 0, 0);
        cycle(0, 0, 1, 1, 0);
        ntot++;
        if (wgt_out !== 24'h807F01)
            $display("FAIL swap_wins got %h exp 807f01", wgt_out);
        else npass++;
        ntot++;
        if ($signed(wgt_out[2*DW +: DW]) != -128)
            $display("FAIL sign_tap2 got %0d exp -128", $signed(wgt_out[2*DW +: DW]));
        else npass++;
    endtask

    task automatic test_clear();
        cycle(1, 8'h0A, 0, 0, 0);
        cycle(1, 8'h0B, 0, 0, 0);
        cycle(1, 8'h0C, 0, 0, 1);
        ntot++;
        if (load_cnt !== CW'(0) || wgt_in_ready !== 1'b1 || wgt_out !== 24'h807F01)
            $display("FAIL clear_load got cnt=%0d rdy=%b out=%h exp 0 1 807f01",
                     load_cnt, wgt_in_ready, wgt_out);
        else npass++;
        cycle(1, 8'h0A, 0, 0, 0);
        cycle(1, 8'h0B, 0, 0, 0);
        cycle(1, 8'h0C, 0, 0, 0);
        cycle(0, 0, 1, 0, 1);
        ntot++;
        if (swap_err !== 1'b0 || load_cnt !== CW'(0) || wgt_out !== 24'h807F01
            || active_valid !== 1'b1)
            $display("FAIL clear_swap got err=%b cnt=%0d out=%h av=%b exp 0 0 807f01 1",
                     swap_err, load_cnt, wgt_out, active_valid);
        else npass++;
    endtask

    task automatic test_midreset();
        cycle(1, 8'h55, 0, 0, 0);
        @(negedge clk);
        rstn = 0;
        #1;
        ntot++;
        if (wgt_out !== '0 || load_cnt !== CW'(0) || active_valid !== 1'b0
            || shadow_full !== 1'b0 || swap_err !== 1'b0)
            $display("FAIL midreset got out=%h cnt=%0d av=%b full=%b err=%b exp all 0",
                     wgt_out, load_cnt, active_valid, shadow_full, swap_err);
        else npass++;
        model_reset();
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic test_random();
        bit v, s, r, c;
        logic [DW-1:0] w;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 99) < 60);
            s = ($urandom_range(0, 99) < 18);
            r = ($urandom_range(0, 99) < 20);
            c = ($urandom_range(0, 99) < 4);
            w = DW'($urandom);
            cycle(v, w, s, r, c);
            ntot++;
            if ({wgt_out, active_valid, shadow_full, wgt_in_ready, swap_err, load_cnt}
                !== {m_out(), m_av, (m_cnt == DEPTH), (m_cnt != DEPTH), m_err, CW'(m_cnt)})
                $display("FAIL rand%0d got out=%h av=%b full=%b rdy=%b err=%b cnt=%0d exp out=%h av=%b cnt=%0d err=%b",
                         n, wgt_out, active_valid, shadow_full, wgt_in_ready, swap_err,
                         load_cnt, m_out(), m_av, m_cnt, m_err);
            else npass++;
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_swap();
        test_swap_err();
        test_rot();
        test_swap_rot();
        test_clear();
        test_midreset();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
